// File: rtl/led_pwm_scheduler_if.sv
// Two-requester write port into the LED PWM bank.
// Requesters drive req/ch/duty, the scheduler answers with gnt.
interface led_pwm_scheduler_if #(
  parameter int PWM_BITS = 10
);
  logic                a_req;
  logic [2:0]          a_ch;
  logic [PWM_BITS-1:0] a_duty;
  logic                a_gnt;
  logic                b_req;
  logic [2:0]          b_ch;
  logic [PWM_BITS-1:0] b_duty;
  logic                b_gnt;

  modport master (
    output a_req, a_ch, a_duty,
    output b_req, b_ch, b_duty,
    input  a_gnt, b_gnt
  );

  modport slave (
    input  a_req, a_ch, a_duty,
    input  b_req, b_ch, b_duty,
    output a_gnt, b_gnt
  );
endinterface

// File: rtl/led_pwm_scheduler.sv
// Round-robin shared LED PWM bank with shadow duty registers
// committed to the active set only at a period boundary.
module led_pwm_scheduler #(
  parameter int CHANNELS = 8,
  parameter int PWM_BITS = 10
) (
  input  logic                clk,
  input  logic                resetn,
  led_pwm_scheduler_if.slave  wr,
  input  logic                freeze,
  output logic [CHANNELS-1:0] led,
  output logic                frame_start,
  output logic                wr_err
);

  localparam logic [3:0] CH_LIM = 4'(CHANNELS);

  logic                a_next;
  logic [PWM_BITS-1:0] pwm_ctr;
  logic [PWM_BITS-1:0] shadow [CHANNELS];
  logic [PWM_BITS-1:0] active [CHANNELS];

  logic                w_en;
  logic [2:0]          w_ch;
  logic [PWM_BITS-1:0] w_duty;
  logic                ch_ok;
  logic                wrap;

  assign wr.a_gnt = wr.a_req & (a_next | ~wr.b_req);
  assign wr.b_gnt = wr.b_req & (~a_next | ~wr.a_req);

  assign w_en   = wr.a_gnt | wr.b_gnt;
  assign w_ch   = wr.a_gnt ? wr.a_ch : wr.b_ch;
  assign w_duty = wr.a_gnt ? wr.a_duty : wr.b_duty;
  assign ch_ok  = {1'b0, w_ch} < CH_LIM;
  assign wrap   = &pwm_ctr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_next      <= 1'b1;
      pwm_ctr     <= '0;
      frame_start <= 1'b0;
      wr_err      <= 1'b0;
      led         <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      pwm_ctr     <= pwm_ctr + 1'b1;
      frame_start <= (pwm_ctr == '0);
      wr_err      <= w_en & ~ch_ok;
      if (w_en)
        a_next <= wr.b_gnt;
      // commit samples shadow before this edge's write lands
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_en && w_ch == 3'(i))
          shadow[i] <= w_duty;
        if (wrap && !freeze)
          active[i] <= shadow[i];
        led[i] <= (pwm_ctr < active[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_scheduler.sv
// Bench for led_pwm_scheduler: vector table plus hand sequences,
// expected duty counts flow through a commit scoreboard.
module tb_led_pwm_scheduler;

  typedef struct {
    bit side;
    int ch;
    int duty;
    int at;
    int hi;
  } vec_t;

  typedef struct {
    int ch;
    int hi;
  } sb_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       freeze;
  logic       freeze6;
  logic [7:0] led;
  logic [5:0] led6;
  logic       frame_start;
  logic       frame_start6;
  logic       wr_err;
  logic       wr_err6;
  logic [9:0] tb_ctr;

  int checks   = 0;
  int failures = 0;
  int cnt    [8];
  int exp_hi [8];
  int wait_n;
  bit unfreeze;
  bit mdl_a_next;
  sb_t  q [$];
  vec_t vt [5];

  led_pwm_scheduler_if #(.PWM_BITS(10)) w0 ();
  led_pwm_scheduler_if #(.PWM_BITS(10)) w1 ();

  led_pwm_scheduler #(
    .CHANNELS(8),
    .PWM_BITS(10)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .wr          (w0),
    .freeze      (freeze),
    .led         (led),
    .frame_start (frame_start),
    .wr_err      (wr_err)
  );

  led_pwm_scheduler #(
    .CHANNELS(6),
    .PWM_BITS(10)
  ) dut6 (
    .clk         (clk),
    .resetn      (resetn),
    .wr          (w1),
    .freeze      (freeze6),
    .led         (led6),
    .frame_start (frame_start6),
    .wr_err      (wr_err6)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) tb_ctr <= '0;
    else         tb_ctr <= tb_ctr + 10'd1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ctr(input int t);
    int n = 0;
    @(negedge clk);
    while (int'(tb_ctr) != t && n < 2100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2100) chk("wait_ctr_timeout", 0, 1);
  endtask

  task automatic do_write(input bit side, input int ch, input int duty);
    int n = 0;
    if (!side) begin
      w0.a_req  = 1'b1;
      w0.a_ch   = 3'(ch);
      w0.a_duty = 10'(duty);
    end else begin
      w0.b_req  = 1'b1;
      w0.b_ch   = 3'(ch);
      w0.b_duty = 10'(duty);
    end
    #1;
    while (!(side ? w0.b_gnt : w0.a_gnt) && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 8) chk("grant_timeout", 0, 1);
    @(posedge clk);
    #1;
    w0.a_req = 1'b0;
    w0.b_req = 1'b0;
    mdl_a_next = side;
  endtask

  task automatic push(input int ch, input int hi);
    sb_t e;
    e.ch = ch;
    e.hi = hi;
    q.push_back(e);
  endtask

  task automatic commit_model();
    sb_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      exp_hi[e.ch] = e.hi;
    end
  endtask

  task automatic measure(input string tag);
    int n  = 0;
    int fs = 0;
    int c6 = 0;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    @(negedge clk);
    while (!frame_start && n < 2100) begin
      @(negedge clk);
      n++;
    end
    wait_n = n;
    if (n >= 2100) chk({tag, "_fs_timeout"}, 0, 1);
    for (int k = 0; k < 1024; k++) begin
      if (k > 0) @(negedge clk);
      if (unfreeze && k == 10) freeze = 1'b0;
      for (int i = 0; i < 8; i++)
        if (led[i]) cnt[i]++;
      if (led6 != '0) c6++;
      if (frame_start) fs++;
    end
    chk({tag, "_fs_pulses"}, fs, 1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_led%0d_high", tag, i), cnt[i], exp_hi[i]);
    chk({tag, "_led6_high"}, c6, 0);
  endtask

  initial begin
    int  c;
    int  ai;
    int  bi;
    bit  exp_a;
    int  a_ch_l [2];
    int  a_dt_l [2];
    int  b_ch_l [2];
    int  b_dt_l [2];

    vt[0] = '{side: 1'b1, ch: 1, duty: 1,    at: 100, hi: 1};
    vt[1] = '{side: 1'b0, ch: 6, duty: 1022, at: 200, hi: 1022};
    vt[2] = '{side: 1'b1, ch: 5, duty: 0,    at: 300, hi: 0};
    vt[3] = '{side: 1'b0, ch: 2, duty: 300,  at: 400, hi: 300};
    vt[4] = '{side: 1'b1, ch: 2, duty: 77,   at: 500, hi: 77};

    a_ch_l = '{3, 5};
    a_dt_l = '{100, 40};
    b_ch_l = '{4, 6};
    b_dt_l = '{700, 1};

    for (int i = 0; i < 8; i++) exp_hi[i] = 0;
    mdl_a_next = 1'b1;
    unfreeze   = 1'b0;
    resetn  = 1'b0;
    freeze  = 1'b0;
    freeze6 = 1'b0;
    w0.a_req = 1'b0; w0.a_ch = '0; w0.a_duty = '0;
    w0.b_req = 1'b0; w0.b_ch = '0; w0.b_duty = '0;
    w1.a_req = 1'b0; w1.a_ch = '0; w1.a_duty = '0;
    w1.b_req = 1'b0; w1.b_ch = '0; w1.b_duty = '0;

    // reset state and pointer
    repeat (3) @(negedge clk);
    chk("rst_led", int'(led), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_wr_err", int'(wr_err), 0);
    w0.a_req = 1'b1;
    w0.b_req = 1'b1;
    #1;
    chk("rst_a_gnt", int'(w0.a_gnt), 1);
    chk("rst_b_gnt", int'(w0.b_gnt), 0);
    w0.a_req = 1'b0;
    w0.b_req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("fs_after_release", int'(frame_start), 1);

    // single write mid-period
    wait_ctr(100);
    do_write(1'b0, 2, 512);
    push(2, 512);
    c = 0;
    do begin
      @(negedge clk);
      if (led[2]) c++;
    end while (int'(tb_ctr) != 0);
    chk("prewrap_led2", c, 0);
    commit_model();
    measure("single");

    // vector table, later write to a channel wins
    for (int v = 0; v < 5; v++) begin
      wait_ctr(vt[v].at);
      do_write(vt[v].side, vt[v].ch, vt[v].duty);
      push(vt[v].ch, vt[v].hi);
    end
    wait_ctr(1023);
    commit_model();
    measure("table");

    // contention, both requesters held
    wait_ctr(20);
    ai = 0;
    bi = 0;
    w0.a_req = 1'b1; w0.a_ch = 3'(a_ch_l[0]); w0.a_duty = 10'(a_dt_l[0]);
    w0.b_req = 1'b1; w0.b_ch = 3'(b_ch_l[0]); w0.b_duty = 10'(b_dt_l[0]);
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      exp_a = w0.a_req & (mdl_a_next | ~w0.b_req);
      chk($sformatf("cont%0d_a_gnt", cyc), int'(w0.a_gnt), int'(exp_a));
      chk($sformatf("cont%0d_b_gnt", cyc), int'(w0.b_gnt), int'(!exp_a));
      @(posedge clk);
      #1;
      if (exp_a) begin
        push(a_ch_l[ai], a_dt_l[ai]);
        ai++;
        mdl_a_next = 1'b0;
        if (ai < 2) begin
          w0.a_ch   = 3'(a_ch_l[ai]);
          w0.a_duty = 10'(a_dt_l[ai]);
        end else w0.a_req = 1'b0;
      end else begin
        push(b_ch_l[bi], b_dt_l[bi]);
        bi++;
        mdl_a_next = 1'b1;
        if (bi < 2) begin
          w0.b_ch   = 3'(b_ch_l[bi]);
          w0.b_duty = 10'(b_dt_l[bi]);
        end else w0.b_req = 1'b0;
      end
      @(negedge clk);
    end
    chk("cont_a_done", ai, 2);
    chk("cont_b_done", bi, 2);
    wait_ctr(1023);
    commit_model();
    measure("contention");

    // write landing on the wrap edge
    wait_ctr(500);
    do_write(1'b0, 0, 50);
    push(0, 50);
    wait_ctr(1023);
    commit_model();
    do_write(1'b1, 0, 1023);
    push(0, 1023);
    measure("collide_old");
    commit_model();
    measure("collide_new");

    // freeze across a wrap
    wait_ctr(300);
    freeze = 1'b1;
    do_write(1'b0, 7, 300);
    push(7, 300);
    unfreeze = 1'b1;
    measure("frozen");
    unfreeze = 1'b0;
    commit_model();
    measure("thawed");

    // bad channel on the 6-channel bank
    wait_ctr(100);
    w1.a_req  = 1'b1;
    w1.a_ch   = 3'd6;
    w1.a_duty = 10'd999;
    #1;
    chk("bad_a_gnt", int'(w1.a_gnt), 1);
    @(posedge clk);
    #1;
    w1.a_req = 1'b0;
    @(negedge clk);
    chk("bad_wr_err_pulse", int'(wr_err6), 1);
    chk("good_wr_err_quiet", int'(wr_err), 0);
    @(negedge clk);
    chk("bad_wr_err_clear", int'(wr_err6), 0);
    measure("badch");

    // mid-run reset
    wait_ctr(5);
    chk("prerst_led0", int'(led[0]), 1);
    w0.a_req = 1'b1;
    w0.b_req = 1'b1;
    resetn = 1'b0;
    #1;
    chk("midrst_led", int'(led), 0);
    chk("midrst_fs", int'(frame_start), 0);
    chk("midrst_a_gnt", int'(w0.a_gnt), 1);
    chk("midrst_b_gnt", int'(w0.b_gnt), 0);
    w0.a_req = 1'b0;
    w0.b_req = 1'b0;
    mdl_a_next = 1'b1;
    q.delete();
    for (int i = 0; i < 8; i++) exp_hi[i] = 0;
    @(negedge clk);
    resetn = 1'b1;
    measure("postrst");
    chk("postrst_fs_delay", wait_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
